// File: rtl/tick_checker_if.sv
// rtl/tick_checker_if.sv - tick producer/checker signal bundle
//
// Groups the run request, the tick event and the checker's status outputs.
//   master : drives enable, tick, tick_data; observes status
//   slave  : the checker; observes enable, tick, tick_data; drives status
// CNT_W must match the CNT_W of the attached tick_checker.

interface tick_checker_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             tick;
    logic [3:0]       tick_data;
    logic [3:0]       last_data;
    logic [CNT_W-1:0] interval;
    logic [7:0]       event_cnt;
    logic             err_early;
    logic             timeout;
    logic             done;

    modport master (
        output enable, tick, tick_data,
        input  last_data, interval, event_cnt, err_early, timeout, done
    );

    modport slave (
        input  enable, tick, tick_data,
        output last_data, interval, event_cnt, err_early, timeout, done
    );
endinterface

// File: rtl/tick_checker.sv
// rtl/tick_checker.sv - periodic tick interval checker with early/timeout detection
//
// Watches a periodic single-cycle tick and checks each spacing against a
// window PERIOD-TOL .. PERIOD+TOL cycles. A run starts when enable rises,
// completes after NUM_EVENTS accepted ticks, or stops on a missing tick.
// Requires TOL < PERIOD and PERIOD+TOL < 2**CNT_W-1.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   bus (slave)    enable, tick, tick_data in;
//                  last_data, interval, event_cnt, err_early, timeout, done out
//                  (all outputs registered)

module tick_checker #(
    parameter int PERIOD     = 10,
    parameter int TOL        = 1,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst,
    tick_checker_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FIRST = 3'd1,
        RUN        = 3'd2,
        DONE       = 3'd3,
        TIMEOUT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       LAST_EVT = 8'(NUM_EVENTS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       last_data_q, last_data_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [7:0]       event_cnt_q, event_cnt_d;
    logic             err_early_q, err_early_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;

    // event_cnt is zero while waiting for the first tick, so the same
    // increment/compare serves both WAIT_FIRST and RUN.
    logic [7:0] event_inc;
    logic       is_final;
    logic       is_early;
    logic       is_expired;

    assign event_inc  = event_cnt_q + 8'd1;
    assign is_final   = (event_inc == LAST_EVT);
    assign is_early   = (cnt_q < WIN_LO);
    assign is_expired = (cnt_q == WIN_HI);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_data_q <= '0;
            interval_q  <= '0;
            event_cnt_q <= '0;
            err_early_q <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            interval_q  <= interval_d;
            event_cnt_q <= event_cnt_d;
            err_early_q <= err_early_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = WAIT_FIRST;
            end
            WAIT_FIRST: begin
                if (!bus.enable)  state_d = IDLE;
                else if (bus.tick) state_d = is_final ? DONE : RUN;
            end
            RUN: begin
                if (!bus.enable)                 state_d = IDLE;
                else if (bus.tick && is_final)   state_d = DONE;
                else if (!bus.tick && is_expired) state_d = TIMEOUT;
            end
            DONE, TIMEOUT: begin
                if (!bus.enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs. Everything holds by default;
    // err_early is a pulse and therefore defaults low.
    always_comb begin
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        interval_d  = interval_q;
        event_cnt_d = event_cnt_q;
        err_early_d = 1'b0;
        timeout_d   = timeout_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    cnt_d       = '0;
                    last_data_d = '0;
                    interval_d  = '0;
                    event_cnt_d = '0;
                    timeout_d   = 1'b0;
                    done_d      = 1'b0;
                end
            end
            WAIT_FIRST: begin
                // First tick only anchors the timing; no window check.
                if (bus.enable && bus.tick) begin
                    cnt_d       = CNT_ONE;
                    last_data_d = bus.tick_data;
                    event_cnt_d = event_inc;
                    done_d      = is_final;
                end
            end
            RUN: begin
                if (bus.enable) begin
                    if (bus.tick) begin
                        // A tick on the last window cycle wins over expiry.
                        cnt_d       = CNT_ONE;
                        interval_d  = cnt_q;
                        last_data_d = bus.tick_data;
                        event_cnt_d = event_inc;
                        err_early_d = is_early;
                        done_d      = is_final;
                    end else if (is_expired) begin
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.last_data = last_data_q;
    assign bus.interval  = interval_q;
    assign bus.event_cnt = event_cnt_q;
    assign bus.err_early = err_early_q;
    assign bus.timeout   = timeout_q;
    assign bus.done      = done_q;

endmodule
